angelia_i2s_audio_tx: RTL and testbench

Serialises stereo audio samples to the codec data-in pin (CDIN) in I2S format. Sits directly downstream of the BCLK/LRCLK generator and consumes its Bfall/LRfall/LRrise strobes, all synchronous to CLK_IN. Upstream audio logic delivers left/right sample pairs through a valid/ready handshake into a one-pair holding buffer. Each LRCLK frame outputs one pair: left slot while LRCLK is low, right slot while LRCLK is high.

---
 rtl/angelia_audio_pkg.sv | 12 +
 rtl/angelia_i2s_audio_tx_shifter.sv | 40 ++++
 rtl/angelia_i2s_audio_tx.sv | 78 +++++++
 tb/tb_angelia_i2s_audio_tx.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/angelia_audio_pkg.sv
// rtl/angelia_audio_pkg.sv - shared widths and sample-pair type for the audio path
package angelia_audio_pkg;

    localparam int AUDIO_DATA_W = 16;
    localparam int AUDIO_SLOT_W = 32;

    typedef struct packed {
        logic [AUDIO_DATA_W-1:0] left;
        logic [AUDIO_DATA_W-1:0] right;
    } audio_pair_t;

endpackage

// File: rtl/angelia_i2s_audio_tx_shifter.sv
// rtl/angelia_i2s_audio_tx_shifter.sv - i2s_slot_shifter: slot shift register driving CDIN
module i2s_slot_shifter
    import angelia_audio_pkg::*;
#(
    parameter int DATA_W = AUDIO_DATA_W,
    parameter int SLOT_W = AUDIO_SLOT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_word,
    input  logic              bfall,
    input  logic              lj_mode,
    output logic              cdin
);

    logic [SLOT_W-1:0] sr;
    logic [SLOT_W-1:0] load_sr;

    assign load_sr = SLOT_W'(load_word) << (SLOT_W - DATA_W);

    // A load always beats a coincident Bfall; in LJ mode the MSB goes out with the load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr   <= '0;
            cdin <= 1'b0;
        end else if (load) begin
            if (lj_mode) begin
                cdin <= load_sr[SLOT_W-1];
                sr   <= load_sr << 1;
            end else begin
                sr <= load_sr;
            end
        end else if (bfall) begin
            cdin <= sr[SLOT_W-1];
            sr   <= sr << 1;
        end
    end

endmodule

// File: rtl/angelia_i2s_audio_tx.sv
// rtl/angelia_i2s_audio_tx.sv - I2S stereo serialiser with one-pair holding buffer (AUDIO_TX_LJ_EN selects left-justified)
module angelia_i2s_audio_tx
    import angelia_audio_pkg::*;
#(
    parameter int DATA_W = AUDIO_DATA_W,
    parameter int SLOT_W = AUDIO_SLOT_W
) (
    input  logic              CLK_IN,
    input  logic              reset,
    input  logic              Bfall,
    input  logic              LRfall,
    input  logic              LRrise,
    input  logic [DATA_W-1:0] in_left,
    input  logic [DATA_W-1:0] in_right,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              CDIN,
    output logic              underrun
);

`ifdef AUDIO_TX_LJ_EN
    localparam logic LJ_MODE = 1'b1;
`else
    localparam logic LJ_MODE = 1'b0;
`endif

    logic [DATA_W-1:0] hold_l;
    logic [DATA_W-1:0] hold_r;
    logic              hold_full;
    logic [DATA_W-1:0] cur_r;
    logic              accept;
    logic [DATA_W-1:0] left_src;
    logic [DATA_W-1:0] load_word;

    assign in_ready = !hold_full && !reset;
    assign accept   = in_valid && in_ready;
    assign left_src = hold_full ? hold_l : '0;

    // The left sample is consumed straight into the shifter at LRfall, so only
    // the right sample needs to be held for the rest of the frame.
    assign load_word = LRfall ? left_src : cur_r;

    always_ff @(posedge CLK_IN or posedge reset) begin
        if (reset) begin
            hold_l    <= '0;
            hold_r    <= '0;
            hold_full <= 1'b0;
            cur_r     <= '0;
            underrun  <= 1'b0;
        end else begin
            underrun <= LRfall && !hold_full;
            if (accept) begin
                hold_l    <= in_left;
                hold_r    <= in_right;
                hold_full <= 1'b1;
            end else if (LRfall) begin
                hold_full <= 1'b0;
            end
            if (LRfall) begin
                cur_r <= hold_full ? hold_r : '0;
            end
        end
    end

    i2s_slot_shifter #(
        .DATA_W(DATA_W),
        .SLOT_W(SLOT_W)
    ) u_shifter (
        .clk      (CLK_IN),
        .rst      (reset),
        .load     (LRfall || LRrise),
        .load_word(load_word),
        .bfall    (Bfall),
        .lj_mode  (LJ_MODE),
        .cdin     (CDIN)
    );

endmodule

// File: tb/tb_angelia_i2s_audio_tx.sv
// tb/tb_angelia_i2s_audio_tx.sv - scoreboard bench: BCLK/LRCLK strobe model, frame and point checks
module tb_angelia_i2s_audio_tx;
    import angelia_audio_pkg::*;

    localparam int DIV  = 40;
    localparam int HALF = DIV / 2;
`ifdef AUDIO_TX_LJ_EN
    localparam int OFS = 0;
    localparam int LJ  = 1;
`else
    localparam int OFS = 1;
    localparam int LJ  = 0;
`endif

    logic        CLK_IN = 1'b0;
    logic        reset = 1'b1;
    logic        Bfall = 1'b0;
    logic        LRfall = 1'b0;
    logic        LRrise = 1'b0;
    logic [15:0] in_left = '0;
    logic [15:0] in_right = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        CDIN;
    logic        underrun;

    always #5 CLK_IN = ~CLK_IN;

    angelia_i2s_audio_tx dut (
        .CLK_IN  (CLK_IN),
        .reset   (reset),
        .Bfall   (Bfall),
        .LRfall  (LRfall),
        .LRrise  (LRrise),
        .in_left (in_left),
        .in_right(in_right),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .CDIN    (CDIN),
        .underrun(underrun)
    );

    typedef struct {
        audio_pair_t pair;
        logic        ur;
        logic        chk;
    } frame_exp_t;

    typedef struct {
        int cyc;
        int id;
        int exp;
    } point_t;

    frame_exp_t sq[$];
    point_t     pq[$];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int gc = DIV - 1;
    int gb = 63;
    int acc = 0;
    int frames_done = 0;
    logic gen_en = 1'b0;
    logic gen_run = 1'b0;

    always @(posedge CLK_IN) cyc <= cyc + 1;

    // BCLK/LRCLK generator model: Bfall every DIV cycles, LR strobes one cycle after the toggling Bfall.
    initial begin
        wait (gen_en);
        forever begin
            @(posedge CLK_IN);
            #1;
            gc = (gc == DIV - 1) ? 0 : gc + 1;
            if (gc == 0) gb = (gb == 63) ? 0 : gb + 1;
            Bfall   = (gc == 0);
            LRfall  = (gc == 1) && (gb == 0);
            LRrise  = (gc == 1) && (gb == 32);
            gen_run = 1'b1;
        end
    end

    function automatic logic [63:0] frame_bits(logic [15:0] l, logic [15:0] r);
        logic [63:0] f;
        f = '0;
        for (int i = 0; i < 16; i++) begin
            f[OFS + i]      = l[15 - i];
            f[32 + OFS + i] = r[15 - i];
        end
        return f;
    endfunction

    function automatic string pname(int id);
        case (id)
            0: return "in_ready";
            1: return "CDIN";
            2: return "underrun";
            3: return "accept_count";
            default: return "timeout";
        endcase
    endfunction

    // Monitor: point checks, handshake counting and per-frame CDIN capture on BCLK rise.
    initial begin
        point_t      p;
        frame_exp_t  e;
        int          act;
        int          ur_cnt;
        int          ur_bad;
        logic [63:0] got_bits;
        logic [63:0] exp_bits;
        ur_cnt   = 0;
        ur_bad   = 0;
        got_bits = '0;
        forever begin
            @(negedge CLK_IN);
            while (pq.size() > 0 && pq[0].cyc <= cyc) begin
                p = pq.pop_front();
                case (p.id)
                    0: act = int'(in_ready);
                    1: act = int'(CDIN);
                    2: act = int'(underrun);
                    3: act = acc;
                    default: act = 0;
                endcase
                vectors++;
                if (act != p.exp) begin
                    miscompares++;
                    $display("FAIL %s cyc %0d: got %0d expected %0d", pname(p.id), cyc, act, p.exp);
                end
            end
            if (in_valid && in_ready) acc++;
            if (gen_run) begin
                if (gc == 0 && gb == 0) begin
                    ur_cnt = 0;
                    ur_bad = 0;
                end
                if (underrun) begin
                    if (gb == 0 && gc == 2) ur_cnt++;
                    else ur_bad++;
                end
                if (gc == HALF) begin
                    got_bits[gb] = CDIN;
                    if (gb == 63) begin
                        if (sq.size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL frame %0d: got a frame, expected none queued", frames_done);
                        end else begin
                            e = sq.pop_front();
                            if (e.chk) begin
                                exp_bits = frame_bits(e.pair.left, e.pair.right);
                                vectors++;
                                if (got_bits != exp_bits) begin
                                    miscompares++;
                                    $display("FAIL frame %0d bits: got %h expected %h", frames_done, got_bits, exp_bits);
                                end
                                vectors++;
                                if (ur_cnt != int'(e.ur) || ur_bad != 0) begin
                                    miscompares++;
                                    $display("FAIL frame %0d underrun: got %0d pulses (%0d misplaced) expected %0d",
                                             frames_done, ur_cnt, ur_bad, e.ur);
                                end
                            end
                        end
                        frames_done++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK_IN);
        #2;
    endtask

    task automatic expect_pt(input int c, input int id, input int e);
        pq.push_back(point_t'{c, id, e});
    endtask

    task automatic push_frame(input logic [15:0] l, input logic [15:0] r, input logic ur, input logic chk);
        sq.push_back(frame_exp_t'{audio_pair_t'{l, r}, ur, chk});
    endtask

    task automatic offer(input logic [15:0] l, input logic [15:0] r);
        in_left  = l;
        in_right = r;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_lrfall();
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (LRfall) return;
        end
        expect_pt(cyc, 4, 1);
    endtask

    initial begin
        tick();
        expect_pt(cyc, 0, 0);
        expect_pt(cyc, 1, 0);
        expect_pt(cyc, 2, 0);
        tick();
        tick();
        reset = 1'b0;
        expect_pt(cyc, 0, 1);
        offer(16'hA5C3, 16'h8001);
        expect_pt(cyc, 0, 0);
        push_frame(16'hA5C3, 16'h8001, 1'b0, 1'b1);
        gen_en = 1'b1;

        // F0: buffered pair goes out; in_ready recovers the cycle after LRfall.
        wait_lrfall();
        expect_pt(cyc, 3, 1);
        expect_pt(cyc, 0, 0);
        expect_pt(cyc + 1, 0, 1);
        push_frame(16'h0000, 16'h0000, 1'b1, 1'b1);

        // F1: nothing buffered -> single registered underrun pulse.
        wait_lrfall();
        expect_pt(cyc, 3, 1);
        expect_pt(cyc, 2, 0);
        expect_pt(cyc + 1, 2, 1);
        expect_pt(cyc + 2, 2, 0);
        tick();
        in_left  = 16'h1111;
        in_right = 16'h2222;
        in_valid = 1'b1;
        push_frame(16'h1111, 16'h2222, 1'b0, 1'b1);

        // F2/F3: in_valid held high, one acceptance per frame.
        wait_lrfall();
        expect_pt(cyc, 3, 2);
        expect_pt(cyc, 0, 0);
        expect_pt(cyc + 1, 0, 1);
        expect_pt(cyc + 2, 0, 0);
        push_frame(16'h1111, 16'h2222, 1'b0, 1'b1);
        wait_lrfall();
        expect_pt(cyc, 3, 3);
        in_valid = 1'b0;
        push_frame(16'h0000, 16'h0000, 1'b1, 1'b1);

        // F4: handshake on the LRfall cycle with an empty buffer.
        wait_lrfall();
        expect_pt(cyc, 3, 3);
        offer(16'h1234, 16'h5678);
        push_frame(16'h1234, 16'h5678, 1'b0, 1'b1);

        wait_lrfall();
        expect_pt(cyc, 3, 4);
        tick();
        offer(16'hFFFF, 16'hFFFF);
        push_frame(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);

        // F6: reset for 3 cycles mid-left-slot; buffered 5555/AAAA must be discarded.
        wait_lrfall();
        tick();
        offer(16'h5555, 16'hAAAA);
        push_frame(16'h0000, 16'h0000, 1'b1, 1'b1);
        for (int i = 0; i < 2000 && gb != 4; i++) tick();
        expect_pt(cyc, 1, 1);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_pt(cyc, 1, 0);
            expect_pt(cyc, 0, 0);
            tick();
        end
        reset = 1'b0;
        expect_pt(cyc, 0, 1);

        wait_lrfall();
        tick();
        offer(16'h8000, 16'h3FFE);
        push_frame(16'h8000, 16'h3FFE, 1'b0, 1'b1);

        // F8: MSB timing around the first Bfall after LRfall.
        wait_lrfall();
        tick();
        expect_pt(cyc, 1, LJ);
        for (int i = 0; i < 100; i++) begin
            tick();
            if (Bfall) break;
        end
        tick();
        expect_pt(cyc, 1, 1 - LJ);

        for (int i = 0; i < 4000 && frames_done < 9; i++) tick();
        if (frames_done < 9) expect_pt(cyc, 4, 1);
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
